// File: rtl/delay_sampler.sv
// -----------------------------------------------------------------------------
// delay_sampler
//   Samples a serial line at a programmable offset after each bit-launch strobe
//   and assembles WORD_W bits (MSB first) into a word.
//
//   Optional feature macro: EDGE_TRACK_EN
//     When defined, sdi transitions near each sample point are counted per frame
//     and a faster/slower correction pulse is issued alongside valid.
//     When undefined, faster/slower are tied low.
//
// Ports
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   start     in   single-cycle frame start request (ignored while busy)
//   abort     in   synchronous frame abort (priority over start/bit_edge)
//   bit_edge  in   single-cycle strobe marking each serial bit launch
//   delay     in   sample offset in clk cycles (latched per bit)
//   sdi       in   asynchronous serial data input
//   data      out  last completed word
//   valid     out  one-cycle pulse, data updated
//   busy      out  frame in progress
//   overrun   out  one-cycle pulse, bit_edge arrived before the pending sample
//   faster    out  one-cycle request to decrement delay
//   slower    out  one-cycle request to increment delay
// -----------------------------------------------------------------------------
module delay_sampler #(
  parameter int WORD_W  = 16,
  parameter int DELAY_W = 8,
  parameter int GUARD   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_edge,
  input  logic [DELAY_W-1:0] delay,
  input  logic               sdi,
  output logic [WORD_W-1:0]  data,
  output logic               valid,
  output logic               busy,
  output logic               overrun,
  output logic               faster,
  output logic               slower
);

  localparam int BCW = $clog2(WORD_W + 1);
  localparam logic [DELAY_W-1:0] GUARD_D = DELAY_W'(GUARD);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_EDGE = 2'd1,
    S_COUNT     = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [BCW-1:0]      r_bitcnt;
  logic [DELAY_W-1:0]  r_cnt;
  logic [WORD_W-1:0]   r_shift;
  logic [WORD_W-1:0]   r_data;
  logic                r_valid;
  logic                r_overrun;
  logic                r_sync1;
  logic                r_sdi_s;

  logic                w_accept;
  logic                w_load;
  logic                w_sample;
  logic                w_last;
  logic                w_ovr;
  logic [WORD_W-1:0]   w_shift_nxt;

  // Two-flop synchroniser; everything downstream uses r_sdi_s.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sdi_s <= 1'b0;
    end else begin
      r_sync1 <= sdi;
      r_sdi_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Sample fires on the edge where the down-counter is already zero, giving
  // T+delay+1 for a strobe seen at edge T.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_sample = 1'b0;
    w_last   = 1'b0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_accept = 1'b1;
            w_next   = S_WAIT_EDGE;
          end
        end
        S_WAIT_EDGE: begin
          if (bit_edge) begin
            w_load = 1'b1;
            w_next = S_COUNT;
          end
        end
        S_COUNT: begin
          if (r_cnt == '0) begin
            w_sample = 1'b1;
            w_last   = (r_bitcnt == BCW'(1));
            w_next   = w_last ? S_IDLE : S_WAIT_EDGE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // A strobe seen in COUNT, including on the sample edge itself, is an overrun.
  assign w_ovr       = !abort && (r_state == S_COUNT) && bit_edge;
  assign w_shift_nxt = {r_shift[WORD_W-2:0], r_sdi_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt  <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= w_sample && w_last;
      r_overrun <= w_ovr;
      if (abort) begin
        r_bitcnt <= '0;
        r_cnt    <= '0;
        r_shift  <= '0;
      end else begin
        if (w_accept) begin
          r_bitcnt <= BCW'(WORD_W);
          r_shift  <= '0;
        end else if (w_sample) begin
          r_bitcnt <= r_bitcnt - BCW'(1);
          r_shift  <= w_shift_nxt;
        end
        if (w_load) begin
          r_cnt <= delay;
        end else if ((r_state == S_COUNT) && (r_cnt != '0)) begin
          r_cnt <= r_cnt - DELAY_W'(1);
        end
        if (w_sample && w_last) begin
          r_data <= w_shift_nxt;
        end
      end
    end
  end

  assign data    = r_data;
  assign valid   = r_valid;
  assign busy    = (r_state != S_IDLE);
  assign overrun = r_overrun;

  // The MSB of the shift register is shifted out when the word is loaded.
  logic w_unused_msb;
  assign w_unused_msb = r_shift[WORD_W-1];

`ifdef EDGE_TRACK_EN
  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  logic [GW-1:0] r_post;
  logic [7:0]    r_late;
  logic [7:0]    r_early;
  logic          r_faster;
  logic          r_slower;
  logic          w_trans;

  // r_sdi_s is about to change on this edge.
  assign w_trans = r_sync1 ^ r_sdi_s;

  // Late window: the GUARD edges following a sample edge.
  // Early window: the GUARD edges preceding a sample edge (cnt in 1..GUARD).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_post   <= '0;
      r_late   <= '0;
      r_early  <= '0;
      r_faster <= 1'b0;
      r_slower <= 1'b0;
    end else begin
      r_faster <= 1'b0;
      r_slower <= 1'b0;
      if (abort) begin
        r_post <= '0;
      end else if (w_accept) begin
        r_post  <= '0;
        r_late  <= '0;
        r_early <= '0;
      end else begin
        if (w_sample)          r_post <= GW'(GUARD);
        else if (r_post != '0) r_post <= r_post - GW'(1);
        if ((r_post != '0) && w_trans && (r_late != 8'hFF))
          r_late <= r_late + 8'd1;
        if ((r_state == S_COUNT) && (r_cnt != '0) && (r_cnt <= GUARD_D) &&
            w_trans && (r_early != 8'hFF))
          r_early <= r_early + 8'd1;
        if (w_sample && w_last) begin
          r_faster <= (r_late > r_early);
          r_slower <= (r_early > r_late);
        end
      end
    end
  end

  assign faster = r_faster;
  assign slower = r_slower;
`else
  logic w_unused_guard;
  assign w_unused_guard = |GUARD_D;
  assign faster = 1'b0;
  assign slower = 1'b0;
`endif

endmodule
